// File: rtl/msdap_pkg.sv
// Shared types and default sizing for the MSDAP input-side controller.
package msdap_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RJ_COUNT   = 16;
  localparam int DEF_COEF_COUNT = 512;
  localparam int DEF_XDEPTH     = 256;
  localparam int DEF_ZERO_RUN   = 800;

  localparam int DEF_RJ_AW   = $clog2(DEF_RJ_COUNT);
  localparam int DEF_COEF_AW = $clog2(DEF_COEF_COUNT);
  localparam int DEF_X_AW    = $clog2(DEF_XDEPTH);
  localparam int DEF_ZC_W    = $clog2(DEF_ZERO_RUN + 1);

  typedef enum logic [3:0] {
    ST_INIT       = 4'd0,
    ST_WAIT_RJ    = 4'd1,
    ST_READ_RJ    = 4'd2,
    ST_WAIT_COEF  = 4'd3,
    ST_READ_COEF  = 4'd4,
    ST_WAIT_INPUT = 4'd5,
    ST_WORKING    = 4'd6,
    ST_CLEARING   = 4'd7,
    ST_SLEEPING   = 4'd8
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/msdap_zero_detect.sv
// Saturating run-length counter of all-zero stereo samples; requests sleep
// on the sample that completes the run.
module msdap_zero_detect
  import msdap_pkg::*;
#(
  parameter int ZERO_RUN = DEF_ZERO_RUN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sample_valid,
  input  logic i_is_zero,
  input  logic i_rst_cnt,
  output logic o_sleep_req
);

  localparam int ZC_W = $clog2(ZERO_RUN + 1);
  localparam logic [ZC_W-1:0] ZC_LAST = ZC_W'(ZERO_RUN - 1);
  localparam logic [ZC_W-1:0] ZC_FULL = ZC_W'(ZERO_RUN);

  logic [ZC_W-1:0] r_zero_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_rst_cnt) begin
      r_zero_cnt <= '0;
    end else if (i_sample_valid) begin
      if (!i_is_zero)
        r_zero_cnt <= '0;
      else if (r_zero_cnt != ZC_FULL)
        r_zero_cnt <= r_zero_cnt + ZC_W'(1);
    end
  end

  // Combinational so the FSM can leave WORKING on the very sample that completes the run
  assign o_sleep_req = i_sample_valid && i_is_zero && (r_zero_cnt >= ZC_LAST);

endmodule

// File: rtl/msdap_input_ctrl.sv
// MSDAP input controller: loads Rj and coefficient memories, then streams
// stereo samples into the circular X buffer with sleep and flush handling.
//
// state       | meaning
// INIT        | zero-sweep X after clear
// WAIT_RJ     | wait for frame to start Rj load
// READ_RJ     | store RJ_COUNT words into Rj memory
// WAIT_COEF   | wait for frame to start coefficient load
// READ_COEF   | store COEF_COUNT words into coefficient memory
// WAIT_INPUT  | wait for frame to start sample stream
// WORKING     | store every stereo sample, strobe compute engine
// CLEARING    | zero-sweep X after flush
// SLEEPING    | zero run detected, drop zero samples
module msdap_input_ctrl
  import msdap_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RJ_COUNT   = DEF_RJ_COUNT,
  parameter int COEF_COUNT = DEF_COEF_COUNT,
  parameter int XDEPTH     = DEF_XDEPTH,
  parameter int ZERO_RUN   = DEF_ZERO_RUN
) (
  input  logic                          i_dclk,
  input  logic                          i_clear,
  input  logic                          i_frame,
  input  logic                          i_flush,
  input  logic                          i_s2p_valid,
  input  logic [DATA_W-1:0]             i_parallel_l,
  input  logic [DATA_W-1:0]             i_parallel_r,
  output logic                          o_in_ready,
  output logic [3:0]                    o_state,
  output logic                          o_rj_we,
  output logic [$clog2(RJ_COUNT)-1:0]   o_rj_addr,
  output logic                          o_coef_we,
  output logic [$clog2(COEF_COUNT)-1:0] o_coef_addr,
  output logic [DATA_W-1:0]             o_cfg_wdata,
  output logic                          o_x_we,
  output logic [$clog2(XDEPTH)-1:0]     o_x_addr,
  output logic [DATA_W-1:0]             o_xl_wdata,
  output logic [DATA_W-1:0]             o_xr_wdata,
  output logic                          o_sample_strobe,
  output logic                          o_sleep_flag
);

  localparam int RJ_AW   = $clog2(RJ_COUNT);
  localparam int COEF_AW = $clog2(COEF_COUNT);
  localparam int X_AW    = $clog2(XDEPTH);
  localparam int IDX_W   = max_int(max_int(RJ_AW, COEF_AW), X_AW);

  localparam logic [IDX_W-1:0] RJ_LAST   = IDX_W'(RJ_COUNT - 1);
  localparam logic [IDX_W-1:0] COEF_LAST = IDX_W'(COEF_COUNT - 1);
  localparam logic [IDX_W-1:0] X_LAST    = IDX_W'(XDEPTH - 1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [X_AW-1:0]     r_wptr, w_wptr_nxt;
  logic                r_in_ready;
  logic                r_rj_we, w_rj_we_nxt;
  logic [RJ_AW-1:0]    r_rj_addr, w_rj_addr_nxt;
  logic                r_coef_we, w_coef_we_nxt;
  logic [COEF_AW-1:0]  r_coef_addr, w_coef_addr_nxt;
  logic [DATA_W-1:0]   r_cfg_wdata, w_cfg_wdata_nxt;
  logic                r_x_we, w_x_we_nxt;
  logic [X_AW-1:0]     r_x_addr, w_x_addr_nxt;
  logic [DATA_W-1:0]   r_xl_wdata, w_xl_wdata_nxt;
  logic [DATA_W-1:0]   r_xr_wdata, w_xr_wdata_nxt;
  logic                r_strobe, w_strobe_nxt;

  logic w_streaming;
  logic w_flush_go;
  logic w_sample;
  logic w_is_zero;
  logic w_zc_rst;
  logic w_sleep_req;

  assign w_streaming = (r_state == ST_WORKING) || (r_state == ST_SLEEPING);
  assign w_flush_go  = i_flush && w_streaming;
  assign w_sample    = i_s2p_valid && w_streaming && !i_flush;
  assign w_is_zero   = (i_parallel_l == '0) && (i_parallel_r == '0);
  assign w_zc_rst    = w_flush_go || (r_state == ST_CLEARING);

  msdap_zero_detect #(
    .ZERO_RUN (ZERO_RUN)
  ) u_zero_detect (
    .i_clk          (i_dclk),
    .i_rst          (i_clear),
    .i_sample_valid (w_sample),
    .i_is_zero      (w_is_zero),
    .i_rst_cnt      (w_zc_rst),
    .o_sleep_req    (w_sleep_req)
  );

  always_ff @(posedge i_dclk) begin
    if (i_clear)
      r_state <= ST_INIT;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_wptr_nxt      = r_wptr;
    w_rj_we_nxt     = 1'b0;
    w_rj_addr_nxt   = r_rj_addr;
    w_coef_we_nxt   = 1'b0;
    w_coef_addr_nxt = r_coef_addr;
    w_cfg_wdata_nxt = r_cfg_wdata;
    w_x_we_nxt      = 1'b0;
    w_x_addr_nxt    = r_x_addr;
    w_xl_wdata_nxt  = r_xl_wdata;
    w_xr_wdata_nxt  = r_xr_wdata;
    w_strobe_nxt    = 1'b0;

    unique case (r_state)
      ST_INIT, ST_CLEARING: begin
        w_x_we_nxt     = 1'b1;
        w_x_addr_nxt   = r_idx[X_AW-1:0];
        w_xl_wdata_nxt = '0;
        w_xr_wdata_nxt = '0;
        if (r_idx == X_LAST) begin
          w_idx_nxt   = '0;
          w_wptr_nxt  = '0;
          w_state_nxt = (r_state == ST_INIT) ? ST_WAIT_RJ : ST_WAIT_INPUT;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end

      ST_WAIT_RJ: begin
        if (i_frame) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_READ_RJ;
        end
      end

      ST_READ_RJ: begin
        if (i_s2p_valid) begin
          w_rj_we_nxt     = 1'b1;
          w_rj_addr_nxt   = r_idx[RJ_AW-1:0];
          w_cfg_wdata_nxt = i_parallel_l;
          if (r_idx == RJ_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_WAIT_COEF;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end

      ST_WAIT_COEF: begin
        if (i_frame) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_READ_COEF;
        end
      end

      ST_READ_COEF: begin
        if (i_s2p_valid) begin
          w_coef_we_nxt   = 1'b1;
          w_coef_addr_nxt = r_idx[COEF_AW-1:0];
          w_cfg_wdata_nxt = i_parallel_l;
          if (r_idx == COEF_LAST) begin
            w_idx_nxt   = '0;
            w_wptr_nxt  = '0;
            w_state_nxt = ST_WAIT_INPUT;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end

      ST_WAIT_INPUT: begin
        if (i_frame)
          w_state_nxt = ST_WORKING;
      end

      ST_WORKING, ST_SLEEPING: begin
        if (w_flush_go) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_CLEARING;
        end else if (w_sample && !((r_state == ST_SLEEPING) && w_is_zero)) begin
          // In SLEEPING only a nonzero sample reaches here, and it wakes the stream
          w_x_we_nxt     = 1'b1;
          w_x_addr_nxt   = r_wptr;
          w_xl_wdata_nxt = i_parallel_l;
          w_xr_wdata_nxt = i_parallel_r;
          w_strobe_nxt   = 1'b1;
          w_wptr_nxt     = r_wptr + X_AW'(1);
          w_state_nxt    = w_sleep_req ? ST_SLEEPING : ST_WORKING;
        end
      end

      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge i_dclk) begin
    if (i_clear) begin
      r_idx       <= '0;
      r_wptr      <= '0;
      r_in_ready  <= 1'b0;
      r_rj_we     <= 1'b0;
      r_rj_addr   <= '0;
      r_coef_we   <= 1'b0;
      r_coef_addr <= '0;
      r_cfg_wdata <= '0;
      r_x_we      <= 1'b0;
      r_x_addr    <= '0;
      r_xl_wdata  <= '0;
      r_xr_wdata  <= '0;
      r_strobe    <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_wptr      <= w_wptr_nxt;
      r_in_ready  <= (r_state != ST_INIT) && (r_state != ST_CLEARING);
      r_rj_we     <= w_rj_we_nxt;
      r_rj_addr   <= w_rj_addr_nxt;
      r_coef_we   <= w_coef_we_nxt;
      r_coef_addr <= w_coef_addr_nxt;
      r_cfg_wdata <= w_cfg_wdata_nxt;
      r_x_we      <= w_x_we_nxt;
      r_x_addr    <= w_x_addr_nxt;
      r_xl_wdata  <= w_xl_wdata_nxt;
      r_xr_wdata  <= w_xr_wdata_nxt;
      r_strobe    <= w_strobe_nxt;
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_state         = r_state;
  assign o_rj_we         = r_rj_we;
  assign o_rj_addr       = r_rj_addr;
  assign o_coef_we       = r_coef_we;
  assign o_coef_addr     = r_coef_addr;
  assign o_cfg_wdata     = r_cfg_wdata;
  assign o_x_we          = r_x_we;
  assign o_x_addr        = r_x_addr;
  assign o_xl_wdata      = r_xl_wdata;
  assign o_xr_wdata      = r_xr_wdata;
  assign o_sample_strobe = r_strobe;
  assign o_sleep_flag    = (r_state == ST_SLEEPING);

endmodule

// File: tb/tb_msdap_input_ctrl.sv
// Directed/randomized bench for msdap_input_ctrl: a monitor logs every memory
// write and strobe, and a behavioural model predicts the same logs.
module tb_msdap_input_ctrl;

  logic        clk = 1'b0;
  logic        clear, frame, flush, s2p_valid;
  logic [15:0] pl, pr;

  logic        in_ready, rj_we, coef_we, x_we, strobe, sleep;
  logic [3:0]  state;
  logic [3:0]  rj_addr;
  logic [8:0]  coef_addr;
  logic [7:0]  x_addr;
  logic [15:0] cfg, xl, xr;

  msdap_input_ctrl dut (
    .i_dclk          (clk),
    .i_clear         (clear),
    .i_frame         (frame),
    .i_flush         (flush),
    .i_s2p_valid     (s2p_valid),
    .i_parallel_l    (pl),
    .i_parallel_r    (pr),
    .o_in_ready      (in_ready),
    .o_state         (state),
    .o_rj_we         (rj_we),
    .o_rj_addr       (rj_addr),
    .o_coef_we       (coef_we),
    .o_coef_addr     (coef_addr),
    .o_cfg_wdata     (cfg),
    .o_x_we          (x_we),
    .o_x_addr        (x_addr),
    .o_xl_wdata      (xl),
    .o_xr_wdata      (xr),
    .o_sample_strobe (strobe),
    .o_sleep_flag    (sleep)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] a; logic [15:0] l; logic [15:0] r;} xw_t;
  typedef struct packed {logic [8:0] a; logic [15:0] d;} cw_t;

  xw_t xq[$], exp_x[$];
  cw_t rjq[$], exp_rj[$], coefq[$], exp_coef[$];
  int  strobe_n = 0, strobe_orphan = 0, exp_strobe = 0;
  int  checks = 0, failures = 0;

  // Reference model of the sample stream: write pointer, zero run, sleep
  int  m_wptr = 0, m_zero = 0;
  bit  m_sleep = 1'b0;

  always @(negedge clk) begin
    if (x_we)    xq.push_back(xw_t'({x_addr, xl, xr}));
    if (rj_we)   rjq.push_back(cw_t'({5'd0, rj_addr, cfg}));
    if (coef_we) coefq.push_back(cw_t'({coef_addr, cfg}));
    if (strobe) begin
      strobe_n++;
      if (!x_we) strobe_orphan++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_raw(input logic [15:0] l, input logic [15:0] r);
    s2p_valid = 1'b1;
    pl = l;
    pr = r;
    step();
    s2p_valid = 1'b0;
    repeat ($urandom_range(0, 1)) step();
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  task automatic model_sweep();
    for (int i = 0; i < 256; i++) exp_x.push_back(xw_t'({8'(i), 16'h0, 16'h0}));
    m_wptr  = 0;
    m_zero  = 0;
    m_sleep = 1'b0;
  endtask

  task automatic sample(input logic [15:0] l, input logic [15:0] r);
    bit z;
    send_raw(l, r);
    z = (l == 16'h0) && (r == 16'h0);
    if (!(m_sleep && z)) begin
      exp_x.push_back(xw_t'({8'(m_wptr), l, r}));
      exp_strobe++;
      m_wptr = (m_wptr + 1) % 256;
      m_zero = z ? ((m_zero < 800) ? m_zero + 1 : 800) : 0;
      m_sleep = (m_zero == 800);
    end
  endtask

  task automatic load_rj(input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = 16'(i + 1);
      send_raw(d, ~d);
      exp_rj.push_back(cw_t'({9'(i), d}));
    end
  endtask

  task automatic load_coef(input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      send_raw(d, 16'($urandom));
      exp_coef.push_back(cw_t'({9'(i), d}));
    end
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!in_ready && n < budget) begin
      step();
      n++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic cmp_x(input string tag);
    int bad = 0;
    int n;
    n = (xq.size() < exp_x.size()) ? xq.size() : exp_x.size();
    for (int i = 0; i < n; i++) if (xq[i] !== exp_x[i]) bad++;
    check({tag, "_xcount"}, 32'(xq.size()), 32'(exp_x.size()));
    check({tag, "_xdata"}, 32'(bad), 32'd0);
  endtask

  task automatic cmp_cw(input string tag, input cw_t got[$], input cw_t want[$]);
    int bad = 0;
    int n;
    n = (got.size() < want.size()) ? got.size() : want.size();
    for (int i = 0; i < n; i++) if (got[i] !== want[i]) bad++;
    check({tag, "_count"}, 32'(got.size()), 32'(want.size()));
    check({tag, "_data"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] l, r;
    clear = 1'b1; frame = 1'b0; flush = 1'b0; s2p_valid = 1'b0; pl = '0; pr = '0;
    idle(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_enables", 32'({x_we, rj_we, coef_we, strobe, sleep}), 32'd0);
    check("rst_buses", 32'({x_addr, xl, cfg}), 32'd0);

    clear = 1'b0;
    model_sweep();
    wait_ready(400, n);
    check("init_cycles", 32'(n), 32'd257);
    check("init_state", 32'(state), 32'd1);
    cmp_x("init");

    pulse_frame();
    check("rj_enter", 32'(state), 32'd2);
    load_rj(16);
    idle(2);
    cmp_cw("rj", rjq, exp_rj);
    check("rj_done_state", 32'(state), 32'd3);
    send_raw(16'h0011, 16'h0);
    idle(2);
    cmp_cw("rj_extra", rjq, exp_rj);

    pulse_frame();
    check("coef_enter", 32'(state), 32'd4);
    load_coef(512);
    idle(2);
    cmp_cw("coef", coefq, exp_coef);
    check("coef_done_state", 32'(state), 32'd5);

    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(1);
    check("flush_ignored", 32'(state), 32'd5);

    pulse_frame();
    check("work_enter", 32'(state), 32'd6);
    for (int k = 1; k <= 300; k++) sample(16'(k), 16'(-k));
    idle(2);
    cmp_x("ramp");
    if (xq.size() > 512) begin
      check("wrap_prev_addr", 32'(xq[511].a), 32'd255);
      check("wrap_addr", 32'(xq[512].a), 32'd0);
    end
    check("ramp_strobes", 32'(strobe_n), 32'(exp_strobe));

    for (int k = 0; k < 60; k++) begin
      l = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      r = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      sample(l, r);
    end
    sample(16'h0001, 16'h0001);
    idle(2);
    cmp_x("random");

    for (int k = 0; k < 799; k++) sample(16'h0, 16'h0);
    idle(2);
    check("zero799_sleep", 32'(sleep), 32'd0);
    check("zero799_state", 32'(state), 32'd6);
    sample(16'h0, 16'h0);
    idle(2);
    check("zero800_sleep", 32'(sleep), 32'(m_sleep));
    check("zero800_state", 32'(state), 32'd8);
    cmp_x("zero800");

    for (int k = 0; k < 5; k++) sample(16'h0, 16'h0);
    idle(2);
    cmp_x("sleep_drop");
    check("sleep_strobes", 32'(strobe_n), 32'(exp_strobe));

    sample(16'h0003, 16'h0000);
    idle(2);
    check("wake_sleep", 32'(sleep), 32'd0);
    check("wake_state", 32'(state), 32'd6);
    cmp_x("wake");

    flush = 1'b1; s2p_valid = 1'b1; pl = 16'h1234; pr = 16'h4321;
    step();
    flush = 1'b0; s2p_valid = 1'b0;
    check("flush_state", 32'(state), 32'd7);
    model_sweep();
    step();
    check("flush_not_ready", 32'(in_ready), 32'd0);
    wait_ready(400, n);
    check("clear_cycles", 32'(n), 32'd256);
    check("clear_done_state", 32'(state), 32'd5);
    cmp_x("flush");

    pulse_frame();
    sample(16'h55AA, 16'h0001);
    idle(2);
    cmp_x("post_flush");

    clear = 1'b1;
    step();
    clear = 1'b0;
    model_sweep();
    wait_ready(400, n);
    pulse_frame();
    load_rj(16);
    pulse_frame();
    load_coef(100);
    clear = 1'b1; s2p_valid = 1'b1; pl = 16'hBEEF; pr = 16'h0;
    step();
    check("abort_state", 32'(state), 32'd0);
    check("abort_enables", 32'({x_we, rj_we, coef_we, strobe, in_ready}), 32'd0);
    clear = 1'b0; s2p_valid = 1'b0;
    model_sweep();
    step();
    check("abort_sweep_start", 32'({x_we, x_addr}), 32'({1'b1, 8'h00}));
    wait_ready(400, n);
    cmp_x("abort");
    cmp_cw("abort_rj", rjq, exp_rj);
    cmp_cw("abort_coef", coefq, exp_coef);
    check("final_strobes", 32'(strobe_n), 32'(exp_strobe));
    check("strobe_orphans", 32'(strobe_orphan), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
